// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared ALU codes, funct values, muldiv encoding and FSM states
package alu_ctrl_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SRA = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;

    localparam logic [1:0] MD_NONE = 2'b00;
    localparam logic [1:0] MD_MULT = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_MD_BUSY = 2'b01,
        ST_MD_DONE = 2'b10
    } state_e;

    typedef struct packed {
        logic [2:0] alu_control;
        logic       shift;
        logic [1:0] md_op;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/alu_funct_dec.sv
// rtl/alu_funct_dec.sv - combinational alu_op/funct decoder
module alu_funct_dec
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       shift,
    output logic [1:0] md_op,
    output logic       illegal
);

    always_comb begin
        alu_control = ALU_AND;
        shift       = 1'b0;
        md_op       = MD_NONE;
        illegal     = 1'b0;
        case (alu_op)
            2'b00: alu_control = ALU_ADD;
            2'b01: alu_control = ALU_SUB;
            default: begin
                // shift is only raised on the R-type path, never for alu_op 0x
                case (funct)
                    F_ADD:  alu_control = ALU_ADD;
                    F_SUB:  alu_control = ALU_SUB;
                    F_AND:  alu_control = ALU_AND;
                    F_OR:   alu_control = ALU_OR;
                    F_SLT:  alu_control = ALU_SLT;
                    F_SLL:  begin alu_control = ALU_SLL; shift = 1'b1; end
                    F_SRL:  begin alu_control = ALU_SRL; shift = 1'b1; end
                    F_SRA:  begin alu_control = ALU_SRA; shift = 1'b1; end
                    F_MULT: md_op = MD_MULT;
                    F_DIV:  md_op = MD_DIV;
                    default: illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - registered handshaked ALU control stage with MULT/DIV sequencing (option: ALU_CTRL_STICKY_ERR_EN)
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W    = 3,
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = 8
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_control,
    output logic              shift,
    output logic              md_start,
    output logic [1:0]        md_op,
    output logic              illegal
`ifdef ALU_CTRL_STICKY_ERR_EN
    ,
    output logic              err_sticky
`endif
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dec_t             res_q, res_d;
    dec_t             dec_w;
    logic             out_valid_q, out_valid_d;
    logic             md_start_q, md_start_d;
    logic             accept;
    logic             is_md;

    alu_funct_dec u_dec (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (dec_w.alu_control),
        .shift       (dec_w.shift),
        .md_op       (dec_w.md_op),
        .illegal     (dec_w.illegal)
    );

    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_md    = (dec_w.md_op != MD_NONE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        md_start_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
                // an accept in the same cycle as the output handshake replaces the result
                if (accept) begin
                    res_d = dec_w;
                    if (is_md) begin
                        state_d     = ST_MD_BUSY;
                        cnt_d       = CNT_W'(MD_CYCLES - 1);
                        md_start_d  = 1'b1;
                        out_valid_d = 1'b0;
                    end else begin
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_MD_BUSY: begin
                if (cnt_q == '0) begin
                    state_d     = ST_MD_DONE;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_MD_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            md_start_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            md_start_q  <= md_start_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign alu_control = CTRL_W'(res_q.alu_control);
    assign shift       = res_q.shift;
    assign md_op       = res_q.md_op;
    assign illegal     = res_q.illegal;
    assign md_start    = md_start_q;

`ifdef ALU_CTRL_STICKY_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (accept && dec_w.illegal) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_sticky = err_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - scoreboard bench for alu_ctrl_seq (optionally with ALU_CTRL_STICKY_ERR_EN)
module tb_alu_ctrl_seq;

    localparam int CW  = 4;
    localparam int MDC = 4;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready, out_valid, out_ready;
    logic          shift, md_start, illegal;
    logic [1:0]    alu_op, md_op;
    logic [5:0]    funct;
    logic [CW-1:0] alu_control;
`ifdef ALU_CTRL_STICKY_ERR_EN
    logic          err_sticky;
    logic          sticky_m = 1'b0;
`endif

    alu_ctrl_seq #(.CTRL_W(CW), .MD_CYCLES(MDC), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_op      (alu_op),
        .funct       (funct),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_control (alu_control),
        .shift       (shift),
        .md_start    (md_start),
        .md_op       (md_op),
        .illegal     (illegal)
`ifdef ALU_CTRL_STICKY_ERR_EN
        ,
        .err_sticky  (err_sticky)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ctrl;
        logic       sh;
        logic [1:0] md;
        logic       ill;
        int         acc;
    } exp_t;

    exp_t sbq[$];
    int   total = 0, bad = 0;
    int   cyc = 0;
    int   md_expect_cyc = -1;
    int   md_accepts = 0, md_pulses = 0;
    logic rnd_ready = 1'b0;

    // opcode table: ADD SUB AND OR SLT SLL SRL SRA MULT DIV
    logic [5:0] ftab [10] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                              6'b000000, 6'b000010, 6'b000011, 6'b011000, 6'b011010};
    logic [2:0] ctab [10] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111,
                              3'b011, 3'b100, 3'b101, 3'b000, 3'b000};
    logic [1:0] mtab [10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
    logic       stab [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [5:0] f);
        exp_t e;
        e.ctrl = 3'b000; e.sh = 1'b0; e.md = 2'd0; e.ill = 1'b0; e.acc = 0;
        if (op == 2'b00) e.ctrl = 3'b010;
        else if (op == 2'b01) e.ctrl = 3'b110;
        else begin
            e.ill = 1'b1;
            for (int i = 0; i < 10; i++) begin
                if (ftab[i] == f) begin
                    e.ctrl = ctab[i]; e.md = mtab[i]; e.sh = stab[i]; e.ill = 1'b0;
                end
            end
        end
        return e;
    endfunction

    function automatic logic md_open();
        foreach (sbq[i]) if (sbq[i].md != 2'd0) return 1'b1;
        return 1'b0;
    endfunction

    // one cycle: drive at posedge+1, check/record at posedge+4 (before the monitor at negedge)
    task automatic issue(input logic v, input logic [1:0] op, input logic [5:0] f);
        exp_t e;
        @(posedge clk);
        #1 in_valid = v; alu_op = op; funct = f;
        #3;
        chk("in_ready", in_ready, !md_open() && (!out_valid || out_ready));
`ifdef ALU_CTRL_STICKY_ERR_EN
        chk("err_sticky", err_sticky, sticky_m);
`endif
        if (in_valid && in_ready) begin
            e = model(op, f);
            e.acc = cyc;
            sbq.push_back(e);
            if (e.md != 2'd0) begin
                md_expect_cyc = cyc + 1;
                md_accepts++;
            end
`ifdef ALU_CTRL_STICKY_ERR_EN
            sticky_m = sticky_m | e.ill;
`endif
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1 out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // monitor: latency, handshake values, hold stability, md_start timing
    initial begin
        exp_t          e;
        logic          fresh = 1'b1, prev_held = 1'b0;
        logic [CW-1:0] p_ctrl;
        logic          p_sh, p_ill;
        logic [1:0]    p_md;
        forever begin
            @(negedge clk);
            if (reset) begin
                fresh = 1'b1;
                prev_held = 1'b0;
            end else begin
                if (prev_held) begin
                    chk("hold_valid", out_valid, 1'b1);
                    chk("hold_ctrl", alu_control, p_ctrl);
                    chk("hold_shift", shift, p_sh);
                    chk("hold_md_op", md_op, p_md);
                    chk("hold_illegal", illegal, p_ill);
                end
                if (md_start) begin
                    chk("md_start_cycle", cyc, md_expect_cyc);
                    md_pulses++;
                end
                if (out_valid) begin
                    if (sbq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL spurious_out_valid: got 1 expected 0 (cycle %0d)", cyc);
                    end else begin
                        if (fresh) begin
                            chk("latency", cyc - sbq[0].acc, (sbq[0].md != 2'd0) ? MDC + 1 : 1);
                            fresh = 1'b0;
                        end
                        if (out_ready) begin
                            e = sbq.pop_front();
                            chk("alu_control", alu_control, {1'b0, e.ctrl});
                            chk("shift", shift, e.sh);
                            chk("md_op", md_op, e.md);
                            chk("illegal", illegal, e.ill);
                            fresh = 1'b1;
                        end
                    end
                end
                prev_held = out_valid && !out_ready;
                p_ctrl = alu_control; p_sh = shift; p_md = md_op; p_ill = illegal;
            end
        end
    end

    initial begin
        logic       v;
        logic [1:0] op;
        logic [5:0] f;
        int         n;
        reset = 1'b1; in_valid = 1'b0; alu_op = 2'b00; funct = 6'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #4;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_alu_control", alu_control, '0);
        chk("rst_shift", shift, 1'b0);
        chk("rst_md_start", md_start, 1'b0);
        chk("rst_md_op", md_op, 2'b00);
        chk("rst_illegal", illegal, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;

        issue(1'b1, 2'b10, 6'b100010);
        issue(1'b1, 2'b00, 6'b000000);
        issue(1'b1, 2'b10, 6'b000000);
        issue(1'b1, 2'b10, 6'b000010);
        issue(1'b1, 2'b10, 6'b000011);
        issue(1'b1, 2'b10, 6'b111111);
        issue(1'b1, 2'b10, 6'b011000);
        repeat (8) issue(1'b0, 2'b00, 6'd0);
        issue(1'b1, 2'b01, 6'b100000);
        repeat (3) issue(1'b0, 2'b00, 6'd0);

        // DIV aborted by reset on its second busy cycle
        issue(1'b1, 2'b11, 6'b011010);
        issue(1'b0, 2'b00, 6'd0);
        @(posedge clk);
        #1 reset = 1'b1; in_valid = 1'b0;
        sbq.delete();
`ifdef ALU_CTRL_STICKY_ERR_EN
        sticky_m = 1'b0;
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        #3;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_md_op", md_op, 2'b00);
        chk("abort_md_start", md_start, 1'b0);
        chk("abort_alu_control", alu_control, '0);
        repeat (6) issue(1'b0, 2'b00, 6'd0);

        rnd_ready = 1'b1;
        repeat (500) begin
            v  = ($urandom_range(0, 3) != 0);
            op = 2'($urandom);
            f  = ($urandom_range(0, 2) == 0) ? 6'($urandom) : ftab[$urandom_range(0, 9)];
            issue(v, op, f);
        end

        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            issue(1'b0, 2'b00, 6'd0);
            n++;
        end
        chk("drain_left", sbq.size(), 0);
        chk("md_pulse_count", md_pulses, md_accepts);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
